// File: rtl/tvip_axi_write_arbiter.sv
// ----------------------------------------------------------------------------
// tvip_axi_write_arbiter
//
// Shares one downstream AXI4 write port (AW/W/B) among NUM_REQUESTERS upstream
// write masters.
//   AW : round-robin arbitration with a registered grant (IDLE -> HOLD).
//   W  : routed combinationally from the head of an order FIFO holding the
//        requester index of every accepted AW whose burst is not yet done.
//   B  : routed back using the requester index prepended to AWID.
//
// Optional feature macro: TVIP_AXI_WRITE_ARBITER_QOS_EN
//   defined   -> highest s_awqos wins, ties resolved in round-robin order
//   undefined -> pure round-robin, s_awqos only forwarded on m_awqos
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   s_aw*                 per-requester AW channel, requester i at slice i
//   s_w*                  per-requester W channel
//   s_b*                  per-requester B channel (s_bresp broadcast)
//   m_aw*                 downstream AW, m_awid = {index, awid}
//   m_w*                  downstream W
//   m_b*                  downstream B, m_bid top bits select the requester
// ----------------------------------------------------------------------------
module tvip_axi_write_arbiter #(
    parameter int NUM_REQUESTERS  = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_WIDTH  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int M_ID_WIDTH = ID_WIDTH + IDX_WIDTH
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [NUM_REQUESTERS-1:0]                s_awvalid,
    output logic [NUM_REQUESTERS-1:0]                s_awready,
    input  logic [NUM_REQUESTERS*ID_WIDTH-1:0]       s_awid,
    input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0]  s_awaddr,
    input  logic [NUM_REQUESTERS*8-1:0]              s_awlen,
    input  logic [NUM_REQUESTERS*3-1:0]              s_awsize,
    input  logic [NUM_REQUESTERS*2-1:0]              s_awburst,
    input  logic [NUM_REQUESTERS*4-1:0]              s_awqos,
    input  logic [NUM_REQUESTERS-1:0]                s_wvalid,
    output logic [NUM_REQUESTERS-1:0]                s_wready,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]     s_wdata,
    input  logic [NUM_REQUESTERS*STRB_WIDTH-1:0]     s_wstrb,
    input  logic [NUM_REQUESTERS-1:0]                s_wlast,
    output logic [NUM_REQUESTERS-1:0]                s_bvalid,
    input  logic [NUM_REQUESTERS-1:0]                s_bready,
    output logic [NUM_REQUESTERS*ID_WIDTH-1:0]       s_bid,
    output logic [NUM_REQUESTERS*2-1:0]              s_bresp,
    output logic                                     m_awvalid,
    input  logic                                     m_awready,
    output logic [M_ID_WIDTH-1:0]                    m_awid,
    output logic [ADDRESS_WIDTH-1:0]                 m_awaddr,
    output logic [7:0]                               m_awlen,
    output logic [2:0]                               m_awsize,
    output logic [1:0]                               m_awburst,
    output logic [3:0]                               m_awqos,
    output logic                                     m_wvalid,
    input  logic                                     m_wready,
    output logic [DATA_WIDTH-1:0]                    m_wdata,
    output logic [STRB_WIDTH-1:0]                    m_wstrb,
    output logic                                     m_wlast,
    input  logic                                     m_bvalid,
    output logic                                     m_bready,
    input  logic [M_ID_WIDTH-1:0]                    m_bid,
    input  logic [1:0]                               m_bresp
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // ---------------------------------------------------------------- unpack
    logic [ID_WIDTH-1:0]      w_awid_arr    [NUM_REQUESTERS];
    logic [ADDRESS_WIDTH-1:0] w_awaddr_arr  [NUM_REQUESTERS];
    logic [7:0]               w_awlen_arr   [NUM_REQUESTERS];
    logic [2:0]               w_awsize_arr  [NUM_REQUESTERS];
    logic [1:0]               w_awburst_arr [NUM_REQUESTERS];
    logic [3:0]               w_awqos_arr   [NUM_REQUESTERS];
    logic [DATA_WIDTH-1:0]    w_wdata_arr   [NUM_REQUESTERS];
    logic [STRB_WIDTH-1:0]    w_wstrb_arr   [NUM_REQUESTERS];

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_unpack
        assign w_awid_arr[g]    = s_awid[g*ID_WIDTH +: ID_WIDTH];
        assign w_awaddr_arr[g]  = s_awaddr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_awlen_arr[g]   = s_awlen[g*8 +: 8];
        assign w_awsize_arr[g]  = s_awsize[g*3 +: 3];
        assign w_awburst_arr[g] = s_awburst[g*2 +: 2];
        assign w_awqos_arr[g]   = s_awqos[g*4 +: 4];
        assign w_wdata_arr[g]   = s_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_wstrb_arr[g]   = s_wstrb[g*STRB_WIDTH +: STRB_WIDTH];
    end

    // ---------------------------------------------------------------- state
    state_t                   r_state;
    state_t                   w_state_next;
    logic [IDX_WIDTH-1:0]     r_grant;
    logic [IDX_WIDTH-1:0]     r_last_grant;
    logic [ID_WIDTH-1:0]      r_awid;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [7:0]               r_awlen;
    logic [2:0]               r_awsize;
    logic [1:0]               r_awburst;
    logic [3:0]               r_awqos;

    logic [IDX_WIDTH-1:0]     r_fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic [IDX_WIDTH-1:0]     w_winner;
    logic [IDX_WIDTH-1:0]     w_cand;
    logic                     w_any_req;
    logic                     w_grant;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [IDX_WIDTH-1:0]     w_head;
    logic [IDX_WIDTH-1:0]     w_bidx;
    logic                     w_b_hit;
`ifdef TVIP_AXI_WRITE_ARBITER_QOS_EN
    logic [3:0]               w_best_qos;
`endif

    assign w_fifo_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_fifo_mem[r_rd_ptr];

    // ---------------------------------------------------------- arbitration
    // Scan requesters in round-robin order starting after the last winner.
    // With QoS enabled only a strictly higher QoS displaces the current pick,
    // so equal-QoS ties fall back to the round-robin position.
    always_comb begin
        w_winner  = '0;
        w_cand    = '0;
        w_any_req = 1'b0;
`ifdef TVIP_AXI_WRITE_ARBITER_QOS_EN
        w_best_qos = '0;
`endif
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            w_cand = IDX_WIDTH'((32'(r_last_grant) + 32'd1 + k) % NUM_REQUESTERS);
`ifdef TVIP_AXI_WRITE_ARBITER_QOS_EN
            if (s_awvalid[w_cand] && (!w_any_req || (w_awqos_arr[w_cand] > w_best_qos))) begin
                w_any_req  = 1'b1;
                w_winner   = w_cand;
                w_best_qos = w_awqos_arr[w_cand];
            end
`else
            if (s_awvalid[w_cand] && !w_any_req) begin
                w_any_req = 1'b1;
                w_winner  = w_cand;
            end
`endif
        end
    end

    // Full is judged on the registered count, so a same-cycle pop cannot
    // open a slot for this cycle's grant.
    assign w_grant = !areset && (r_state == ST_IDLE) && w_any_req && !w_fifo_full;

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_awready
        assign s_awready[g] = w_grant && (w_winner == IDX_WIDTH'(g));
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        m_awvalid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_awvalid = !areset;
                if (m_awready) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_WIDTH'(NUM_REQUESTERS - 1);
            r_awid       <= '0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awsize     <= '0;
            r_awburst    <= '0;
            r_awqos      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_awid       <= w_awid_arr[w_winner];
                r_awaddr     <= w_awaddr_arr[w_winner];
                r_awlen      <= w_awlen_arr[w_winner];
                r_awsize     <= w_awsize_arr[w_winner];
                r_awburst    <= w_awburst_arr[w_winner];
                r_awqos      <= w_awqos_arr[w_winner];
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_push) begin
            r_fifo_mem[r_wr_ptr] <= r_grant;
        end
    end

    assign m_awid    = {r_grant, r_awid};
    assign m_awaddr  = r_awaddr;
    assign m_awlen   = r_awlen;
    assign m_awsize  = r_awsize;
    assign m_awburst = r_awburst;
    assign m_awqos   = r_awqos;

    // ----------------------------------------------------------- W routing
    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        if (!areset && !w_fifo_empty) begin
            m_wvalid = s_wvalid[w_head];
            m_wdata  = w_wdata_arr[w_head];
            m_wstrb  = w_wstrb_arr[w_head];
            m_wlast  = s_wlast[w_head];
        end
    end

    assign w_pop = m_wvalid && m_wready && m_wlast;

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_wready
        assign s_wready[g] = !areset && !w_fifo_empty && (w_head == IDX_WIDTH'(g)) && m_wready;
    end

    // ----------------------------------------------------------- B routing
    // Indices beyond the requester count have no owner; those responses
    // are accepted and dropped so the slave is never stalled.
    assign w_bidx   = m_bid[M_ID_WIDTH-1 -: IDX_WIDTH];
    assign w_b_hit  = (int'(w_bidx) < NUM_REQUESTERS);
    assign m_bready = !areset && (w_b_hit ? s_bready[w_bidx] : 1'b1);

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_bresp
        assign s_bvalid[g]                    = !areset && m_bvalid && (w_bidx == IDX_WIDTH'(g));
        assign s_bid[g*ID_WIDTH +: ID_WIDTH]  = (!areset && (w_bidx == IDX_WIDTH'(g))) ? m_bid[ID_WIDTH-1:0] : '0;
        assign s_bresp[g*2 +: 2]              = areset ? 2'b00 : m_bresp;
    end

endmodule

// File: tb/tb_tvip_axi_write_arbiter.sv
module tb_tvip_axi_write_arbiter;
    localparam int N    = 2;
    localparam int IDW  = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MO   = 4;
    localparam int MIDW = IDW + 1;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      s_awvalid, s_awready;
    logic [N*IDW-1:0]  s_awid;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*8-1:0]    s_awlen;
    logic [N*3-1:0]    s_awsize;
    logic [N*2-1:0]    s_awburst;
    logic [N*4-1:0]    s_awqos;
    logic [N-1:0]      s_wvalid, s_wready, s_wlast;
    logic [N*DW-1:0]   s_wdata;
    logic [N*SW-1:0]   s_wstrb;
    logic [N-1:0]      s_bvalid, s_bready;
    logic [N*IDW-1:0]  s_bid;
    logic [N*2-1:0]    s_bresp;
    logic              m_awvalid, m_awready;
    logic [MIDW-1:0]   m_awid;
    logic [AW-1:0]     m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic [3:0]        m_awqos;
    logic              m_wvalid, m_wready, m_wlast;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_bvalid, m_bready;
    logic [MIDW-1:0]   m_bid;
    logic [1:0]        m_bresp;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    tvip_axi_write_arbiter #(
        .NUM_REQUESTERS (N),
        .ID_WIDTH       (IDW),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awqos(s_awqos),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awqos(m_awqos),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_awqos = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
        s_wlast = '0; s_bready = '0; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset = 1'b1;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_wlast = 2'b11; m_wready = 1'b1;
        m_bvalid = 1'b1; m_bid = 5'h17; m_bresp = 2'd2; s_bready = 2'b11;
        tick(); tick(); #1;
        checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rst_m_awvalid got %b exp 0", m_awvalid); end
        checks++; if (s_awready !== 2'b00) begin errors++; $display("FAIL rst_s_awready got %b exp 00", s_awready); end
        checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_m_wvalid got %b exp 0", m_wvalid); end
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL rst_s_wready got %b exp 00", s_wready); end
        checks++; if (s_bvalid !== 2'b00) begin errors++; $display("FAIL rst_s_bvalid got %b exp 00", s_bvalid); end
        checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL rst_m_bready got %b exp 0", m_bready); end
        checks++; if (s_bresp !== 4'b0000) begin errors++; $display("FAIL rst_s_bresp got %b exp 0000", s_bresp); end
        checks++; if (m_awid !== 5'h00) begin errors++; $display("FAIL rst_m_awid got %h exp 00", m_awid); end
        checks++; if (m_awaddr !== 32'h0) begin errors++; $display("FAIL rst_m_awaddr got %h exp 0", m_awaddr); end
        clear_inputs();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_priority();
        s_awid = {4'd5, 4'd3}; s_awaddr = {32'h200, 32'h100}; s_awqos = {4'hA, 4'hA};
        s_awvalid = 2'b11; #1;
        checks++; if (s_awready !== 2'b01) begin errors++; $display("FAIL prio_first_awready got %b exp 01", s_awready); end
        tick(); s_awvalid = 2'b10; #1;
        checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL prio_hold_valid got %b exp 1", m_awvalid); end
        checks++; if (m_awid !== 5'h03) begin errors++; $display("FAIL prio_first_awid got %h exp 03", m_awid); end
        checks++; if (m_awaddr !== 32'h100) begin errors++; $display("FAIL prio_first_awaddr got %h exp 100", m_awaddr); end
        checks++; if (m_awqos !== 4'hA) begin errors++; $display("FAIL prio_awqos got %h exp a", m_awqos); end
        checks++; if (s_awready !== 2'b00) begin errors++; $display("FAIL prio_hold_awready got %b exp 00", s_awready); end
        m_awready = 1'b1; tick(); m_awready = 1'b0; #1;
        checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL prio_idle_valid got %b exp 0", m_awvalid); end
        checks++; if (s_awready !== 2'b10) begin errors++; $display("FAIL prio_second_awready got %b exp 10", s_awready); end
        tick(); s_awvalid = 2'b00; #1;
        checks++; if (m_awid !== 5'h15) begin errors++; $display("FAIL prio_second_awid got %h exp 15", m_awid); end
        checks++; if (m_awaddr !== 32'h200) begin errors++; $display("FAIL prio_second_awaddr got %h exp 200", m_awaddr); end
        tick();
        checks++; if (m_awvalid !== 1'b1 || m_awid !== 5'h15) begin errors++; $display("FAIL prio_stable got valid %b id %h exp 1 15", m_awvalid, m_awid); end
        m_awready = 1'b1; tick(); m_awready = 1'b0;
        s_wvalid = 2'b11; s_wlast = 2'b11; s_wdata = {32'hD1, 32'hD0}; m_wready = 1'b1; #1;
        checks++; if (m_wdata !== 32'hD0 || s_wready !== 2'b01) begin errors++; $display("FAIL prio_w0 got data %h rdy %b exp d0 01", m_wdata, s_wready); end
        tick();
        checks++; if (m_wdata !== 32'hD1 || s_wready !== 2'b10) begin errors++; $display("FAIL prio_w1 got data %h rdy %b exp d1 10", m_wdata, s_wready); end
        tick(); s_wvalid = 2'b00; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL prio_drained got %b exp 00", s_wready); end
        clear_inputs();
    endtask

    task automatic test_w_before_aw();
        s_wvalid = 2'b10; s_wlast = 2'b10; s_wdata = {32'hB1, 32'h0}; m_wready = 1'b1; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL wfirst_held got %b exp 00", s_wready); end
        checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL wfirst_mvalid got %b exp 0", m_wvalid); end
        s_awvalid = 2'b10; s_awid = {4'd2, 4'd0}; #1;
        checks++; if (s_awready !== 2'b10) begin errors++; $display("FAIL wfirst_awready got %b exp 10", s_awready); end
        tick(); s_awvalid = 2'b00; m_awready = 1'b1; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL wfirst_hold_wready got %b exp 00", s_wready); end
        tick(); m_awready = 1'b0; #1;
        checks++; if (m_wvalid !== 1'b1 || s_wready !== 2'b10) begin errors++; $display("FAIL wfirst_pass got valid %b rdy %b exp 1 10", m_wvalid, s_wready); end
        checks++; if (m_wdata !== 32'hB1 || m_wlast !== 1'b1) begin errors++; $display("FAIL wfirst_data got %h last %b exp b1 1", m_wdata, m_wlast); end
        tick(); s_wvalid = 2'b00; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL wfirst_popped got %b exp 00", s_wready); end
        clear_inputs();
    endtask

    task automatic test_order();
        s_wvalid = 2'b10; s_wlast = 2'b10; s_wdata = {32'hC1, 32'h0}; m_wready = 1'b1;
        s_awvalid = 2'b11; s_awlen = {8'd0, 8'd3}; s_awid = {4'd1, 4'd0}; m_awready = 1'b1;
        tick(); s_awvalid = 2'b10;
        tick(); #1;
        checks++; if (s_wready !== 2'b01 || m_wvalid !== 1'b0) begin errors++; $display("FAIL order_head0 got rdy %b valid %b exp 01 0", s_wready, m_wvalid); end
        tick(); s_awvalid = 2'b00;
        tick(); m_awready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_wvalid = 2'b11; s_wdata = {32'hC1, 32'(32'hA0 + b)}; s_wlast = {1'b1, (b == 3)}; #1;
            checks++;
            if (m_wvalid !== 1'b1 || m_wdata !== 32'(32'hA0 + b) || m_wlast !== (b == 3) || s_wready !== 2'b01) begin
                errors++;
                $display("FAIL order_w0_beat%0d got v %b d %h l %b r %b exp 1 %h %b 01", b, m_wvalid, m_wdata, m_wlast, s_wready, 32'hA0 + b, (b == 3));
            end
            tick();
        end
        s_wvalid = 2'b10; #1;
        checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hC1 || s_wready !== 2'b10) begin errors++; $display("FAIL order_w1 got v %b d %h r %b exp 1 c1 10", m_wvalid, m_wdata, s_wready); end
        tick(); s_wvalid = 2'b00; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL order_drained got %b exp 00", s_wready); end
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        s_awvalid = 2'b01; m_awready = 1'b1;
        repeat (8) tick();
        checks++; if (s_awready !== 2'b00 || m_awvalid !== 1'b0) begin errors++; $display("FAIL full_blocked got rdy %b v %b exp 00 0", s_awready, m_awvalid); end
        tick();
        checks++; if (s_awready !== 2'b00) begin errors++; $display("FAIL full_still_blocked got %b exp 00", s_awready); end
        s_wvalid = 2'b01; s_wlast = 2'b01; m_wready = 1'b1; #1;
        checks++; if (s_awready !== 2'b00 || m_wvalid !== 1'b1) begin errors++; $display("FAIL full_same_cycle_pop got rdy %b wv %b exp 00 1", s_awready, m_wvalid); end
        tick(); s_wvalid = 2'b00; #1;
        checks++; if (s_awready !== 2'b01) begin errors++; $display("FAIL full_released got %b exp 01", s_awready); end
        tick(); s_awvalid = 2'b00; #1;
        checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL full_fifth_hold got %b exp 1", m_awvalid); end
        tick(); m_awready = 1'b0;
        s_wvalid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m_wvalid !== 1'b1) begin errors++; $display("FAIL full_drain%0d got %b exp 1", i, m_wvalid); end
            tick();
        end
        s_wvalid = 2'b00; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL full_empty got %b exp 00", s_wready); end
        clear_inputs();
    endtask

    task automatic test_b_routing();
        m_bvalid = 1'b1; m_bid = {1'b1, 4'h7}; m_bresp = 2'd2; s_bready = 2'b00; #1;
        checks++; if (s_bvalid !== 2'b10) begin errors++; $display("FAIL b_valid1 got %b exp 10", s_bvalid); end
        checks++; if (s_bid[7:4] !== 4'h7) begin errors++; $display("FAIL b_id1 got %h exp 7", s_bid[7:4]); end
        checks++; if (s_bresp !== 4'b1010) begin errors++; $display("FAIL b_resp got %b exp 1010", s_bresp); end
        checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL b_ready_low got %b exp 0", m_bready); end
        s_bready = 2'b10; #1;
        checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL b_ready_follow got %b exp 1", m_bready); end
        s_bready = 2'b01; #1;
        checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL b_ready_other got %b exp 0", m_bready); end
        m_bid = {1'b0, 4'hA}; m_bresp = 2'd1; #1;
        checks++; if (s_bvalid !== 2'b01 || s_bid[3:0] !== 4'hA || m_bready !== 1'b1) begin errors++; $display("FAIL b_route0 got v %b id %h r %b exp 01 a 1", s_bvalid, s_bid[3:0], m_bready); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        s_awvalid = 2'b01; s_awlen = {8'd0, 8'd3}; s_awid = {4'd0, 4'd9}; s_awaddr = {32'h0, 32'h300}; m_awready = 1'b1;
        tick(); s_awvalid = 2'b00;
        tick(); m_awready = 1'b0;
        s_wvalid = 2'b01; s_wdata = {32'h0, 32'hE0}; m_wready = 1'b1; #1;
        checks++; if (m_wvalid !== 1'b1) begin errors++; $display("FAIL mid_beat0 got %b exp 1", m_wvalid); end
        tick();
        areset = 1'b1; #1;
        checks++; if (m_wvalid !== 1'b0 || s_wready !== 2'b00) begin errors++; $display("FAIL mid_forced got v %b r %b exp 0 00", m_wvalid, s_wready); end
        tick(); areset = 1'b0; #1;
        checks++; if (m_wvalid !== 1'b0 || s_wready !== 2'b00) begin errors++; $display("FAIL mid_discarded got v %b r %b exp 0 00", m_wvalid, s_wready); end
        checks++; if (m_awid !== 5'h00 || m_awaddr !== 32'h0) begin errors++; $display("FAIL mid_payload got id %h addr %h exp 00 0", m_awid, m_awaddr); end
        s_wvalid = 2'b00; s_awlen = '0; s_awvalid = 2'b11; #1;
        checks++; if (s_awready !== 2'b01) begin errors++; $display("FAIL mid_rr_restart got %b exp 01", s_awready); end
        tick(); s_awvalid = 2'b00; m_awready = 1'b1;
        tick(); m_awready = 1'b0;
        s_wvalid = 2'b01; s_wlast = 2'b01;
        tick(); s_wvalid = 2'b00; #1;
        checks++; if (s_wready !== 2'b00) begin errors++; $display("FAIL mid_clean got %b exp 00", s_wready); end
        clear_inputs();
    endtask

`ifdef TVIP_AXI_WRITE_ARBITER_QOS_EN
    task automatic test_qos();
        s_awvalid = 2'b10; m_awready = 1'b0;
        tick(); s_awvalid = 2'b00; m_awready = 1'b1;
        tick(); m_awready = 1'b0;
        s_wvalid = 2'b10; s_wlast = 2'b10; m_wready = 1'b1;
        tick(); s_wvalid = 2'b00;
        s_awqos = {4'd9, 4'd2}; s_awvalid = 2'b11; #1;
        checks++; if (s_awready !== 2'b10) begin errors++; $display("FAIL qos_high_wins got %b exp 10", s_awready); end
        tick(); s_awvalid = 2'b00; #1;
        checks++; if (m_awqos !== 4'd9) begin errors++; $display("FAIL qos_forward got %h exp 9", m_awqos); end
        m_awready = 1'b1; tick(); m_awready = 1'b0;
        s_wvalid = 2'b10;
        tick(); s_wvalid = 2'b00;
        s_awqos = {4'd5, 4'd5}; s_awvalid = 2'b11; #1;
        checks++; if (s_awready !== 2'b01) begin errors++; $display("FAIL qos_tie_rr got %b exp 01", s_awready); end
        tick(); s_awvalid = 2'b00; m_awready = 1'b1;
        tick(); m_awready = 1'b0;
        s_wvalid = 2'b01; s_wlast = 2'b01;
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout errors %0d exp 0", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        areset = 1'b1;
        test_reset();
        test_priority();
        test_w_before_aw();
        test_order();
        test_fifo_full();
        test_b_routing();
        test_reset_mid_burst();
`ifdef TVIP_AXI_WRITE_ARBITER_QOS_EN
        test_qos();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tvip_axi_write_arbiter.md
# tvip_axi_write_arbiter

Round-robin arbiter sharing one downstream AXI4 write port (AW/W/B) among NUM_REQUESTERS upstream write masters. It sits between tvip_axi master agents/DUT-side masters and a single slave. AW is arbitrated with a registered grant. W is routed in AW-acceptance order through an order FIFO. B is routed back by an index prefix added to AWID.

## Interface
- NUM_REQUESTERS, 2: upstream masters (2..8); IDX_WIDTH = max(1, $clog2(NUM_REQUESTERS))
- ID_WIDTH, 4: upstream ID width; downstream ID width = ID_WIDTH+IDX_WIDTH
- ADDRESS_WIDTH, 32 / DATA_WIDTH, 32: address and data widths; STRB = DATA_WIDTH/8
- MAX_OUTSTANDING, 4: order-FIFO depth (accepted AW whose W burst has not finished), power of 2
- aclk in 1: clock; only clock
- areset in 1: reset, synchronous, active-high
- s_awvalid/s_awready in/out N: per-requester AW handshake
- s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awqos in N×(ID_WIDTH, ADDRESS_WIDTH, 8, 3, 2, 4): packed, requester i at slice i
- s_wvalid/s_wready in/out N; s_wdata, s_wstrb, s_wlast in N×(DATA_WIDTH, STRB, 1)
- s_bvalid out N; s_bready in N; s_bid out N×ID_WIDTH; s_bresp out N×2
- m_awvalid out 1; m_awready in 1; m_awid out ID_WIDTH+IDX_WIDTH ({index, awid}); m_awaddr/len/size/burst/qos out as above
- m_wvalid out 1; m_wready in 1; m_wdata, m_wstrb, m_wlast out
- m_bvalid in 1; m_bready out 1; m_bid in ID_WIDTH+IDX_WIDTH; m_bresp in 2

## Operation
- AW FSM, two states:
  - IDLE: if any s_awvalid and FIFO not full, pick a winner, register grant index and AW payload, go to HOLD. s_awready[winner] pulses in that same cycle.
  - HOLD: m_awvalid=1 with stable payload until m_awready. On handshake, push the index into the FIFO and return to IDLE.
- Round-robin: search starts at last_grant+1 modulo N. last_grant updates on every grant.
- FIFO full (count==MAX_OUTSTANDING): no grant in IDLE, checked before any same-cycle pop. Grant is not blocked by an empty W path.
- W routing, combinational from FIFO head:
  - m_w* = s_w*[head]; s_wready[head] = m_wready; all other s_wready = 0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - FIFO empty: m_wvalid=0 and all s_wready=0. W arriving before its AW is held off.
- Simultaneous push and pop is allowed; count is unchanged.
- B routing: k = m_bid[top IDX_WIDTH bits].
  - s_bvalid[k] = m_bvalid; m_bready = s_bready[k].
  - s_bid[k] = m_bid low ID_WIDTH bits; s_bresp = m_bresp, broadcast.
  - k ≥ N: m_bready=1 and the response is dropped (sink).
- Reset: grant, FIFO, count and state are cleared; last_grant = N-1, so requester 0 wins first.

## Timing
- Latency: s_awvalid to m_awvalid is 1 cycle. The W path and B path are 0 cycles (combinational).
- Back-to-back AW: at most one AW every 2 cycles (HOLD → IDLE → HOLD).
- Reset values: m_awvalid=0, all s_awready=0, m_wvalid=0, all s_wready=0, all s_bvalid=0, m_bready=0, m_aw* payload=0.
- While areset is high, all combinational outputs are forced to 0.
- Reset mid-burst: in-flight AW/W state is discarded at the reset edge. No partial W beat is forwarded after reset.
- m_awvalid never deasserts in HOLD without m_awready (AXI stability rule).

## Configuration
- TVIP_AXI_WRITE_ARBITER_QOS_EN:
  - Defined: the winner is the highest s_awqos among valid requesters. Ties are broken by round-robin order from last_grant+1.
  - Undefined: pure round-robin; s_awqos is only forwarded on m_awqos.

## Test plan
- Reset and priority: reset, then s_awvalid=2'b11 with awid 3/5 → first m_awid={0,3}, second m_awid={1,5}; last_grant alternates.
- W before AW: requester 1 drives W (len 0, wlast=1) with no AW → s_wready[1]=0. After its AW handshake, the beat passes the same cycle m_wready=1.
- Order: AW0 (len 3), then AW1 (len 0) accepted. W1 is offered first → held until all 4 beats of W0 complete, then W1 passes.
- FIFO full: MAX_OUTSTANDING=4, four AWs accepted, no W → fifth s_awvalid gets no s_awready. One wlast pop → fifth AW is granted the next IDLE cycle.
- B routing: m_bid={1,4'h7}, m_bresp=2 → s_bvalid[1]=1, s_bid[1]=7, s_bresp=2; m_bready follows s_bready[1].
- QoS (macro defined): awqos 2 vs 9 with last_grant=1 → requester with qos 9 wins. Equal qos → round-robin.
